// File: rtl/wb_stage.sv
// Write-back stage: retires ALU results directly and loads through a data-memory read with timeout.
// Optional macro WB_FWD_EN adds fwd_valid/fwd_dest/fwd_data forwarding outputs.
module wb_stage #(
  parameter int W   = 8,
  parameter int D   = 4,
  parameter int TMO = 15
) (
  input  logic         CLK,
  input  logic         reset,
  input  logic         ex_valid,
  output logic         ex_ready,
  input  logic         ex_is_load,
  input  logic [D-1:0] ex_dest,
  input  logic [W-1:0] ex_result,
  output logic         mem_req,
  output logic [W-1:0] mem_addr,
  input  logic         mem_ack,
  input  logic [W-1:0] mem_rdata,
  output logic         write_en,
  output logic [D-1:0] wr_dest,
  output logic [W-1:0] data_in,
  output logic         err,
`ifdef WB_FWD_EN
  output logic         fwd_valid,
  output logic [D-1:0] fwd_dest,
  output logic [W-1:0] fwd_data,
`endif
  output logic [1:0]   fsm_state
);

  localparam int CW = $clog2(TMO + 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LOAD_WAIT = 2'd1,
    WRITE     = 2'd2
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;

  assign fsm_state = state;

`ifdef WB_FWD_EN
  assign fwd_valid = write_en;
  assign fwd_dest  = wr_dest;
  assign fwd_data  = data_in;
`endif

  // Handshake: an operation transfers on a rising CLK edge when ex_valid and
  // ex_ready are both 1; ex_ready is 0 only while a load waits for memory.
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      ex_ready <= 1'b1;
      mem_req  <= 1'b0;
      mem_addr <= '0;
      write_en <= 1'b0;
      wr_dest  <= '0;
      data_in  <= '0;
      err      <= 1'b0;
      cnt      <= '0;
    end else begin
      case (state)
        IDLE, WRITE: begin
          write_en <= 1'b0;
          if (ex_valid) begin
            wr_dest <= ex_dest;
            if (ex_is_load) begin
              state    <= LOAD_WAIT;
              ex_ready <= 1'b0;
              mem_req  <= 1'b1;
              mem_addr <= ex_result;
              cnt      <= '0;
            end else begin
              state    <= WRITE;
              write_en <= 1'b1;
              data_in  <= ex_result;
            end
          end else begin
            state <= IDLE;
          end
        end
        LOAD_WAIT: begin
          // A late ack in the final wait cycle still completes the load.
          if (mem_ack) begin
            state    <= WRITE;
            mem_req  <= 1'b0;
            data_in  <= mem_rdata;
            write_en <= 1'b1;
            ex_ready <= 1'b1;
          end else if (cnt == CW'(TMO - 1)) begin
            cnt      <= cnt + 1'b1;
            state    <= IDLE;
            mem_req  <= 1'b0;
            err      <= 1'b1;
            ex_ready <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state    <= IDLE;
          ex_ready <= 1'b1;
          mem_req  <= 1'b0;
          write_en <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage: ALU retire, back-to-back ops, loads, ack timing, timeout and reset abort.
module tb_wb_stage;
  localparam int W = 8;
  localparam int D = 4;

  logic         CLK = 1'b0;
  logic         reset;
  logic         ex_valid;
  logic         ex_ready;
  logic         ex_is_load;
  logic [D-1:0] ex_dest;
  logic [W-1:0] ex_result;
  logic         mem_req;
  logic [W-1:0] mem_addr;
  logic         mem_ack;
  logic [W-1:0] mem_rdata;
  logic         write_en;
  logic [D-1:0] wr_dest;
  logic [W-1:0] data_in;
  logic         err;
  logic [1:0]   fsm_state;
`ifdef WB_FWD_EN
  logic         fwd_valid;
  logic [D-1:0] fwd_dest;
  logic [W-1:0] fwd_data;
`endif

  int total = 0;
  int bad   = 0;

  wb_stage #(.W(W), .D(D), .TMO(15)) dut (
    .CLK(CLK), .reset(reset),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_is_load(ex_is_load),
    .ex_dest(ex_dest), .ex_result(ex_result),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .write_en(write_en), .wr_dest(wr_dest), .data_in(data_in), .err(err),
`ifdef WB_FWD_EN
    .fwd_valid(fwd_valid), .fwd_dest(fwd_dest), .fwd_data(fwd_data),
`endif
    .fsm_state(fsm_state)
  );

  // clock / reset
  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic drive_op(input logic load, input logic [D-1:0] dest, input logic [W-1:0] res);
    ex_valid   = 1'b1;
    ex_is_load = load;
    ex_dest    = dest;
    ex_result  = res;
  endtask

  task automatic drive_idle();
    ex_valid   = 1'b0;
    ex_is_load = 1'b0;
    ex_dest    = '0;
    ex_result  = '0;
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_ready"}, 32'(ex_ready), 32'd1);
    chk({tag, "_req"},   32'(mem_req),  32'd0);
    chk({tag, "_addr"},  32'(mem_addr), 32'd0);
    chk({tag, "_we"},    32'(write_en), 32'd0);
    chk({tag, "_dest"},  32'(wr_dest),  32'd0);
    chk({tag, "_data"},  32'(data_in),  32'd0);
    chk({tag, "_err"},   32'(err),      32'd0);
    chk({tag, "_state"}, 32'(fsm_state), 32'd0);
  endtask

  logic [D-1:0] dests [3] = '{4'd1, 4'd2, 4'd3};
  logic [W-1:0] datas [3] = '{8'h11, 8'h22, 8'h33};

  initial begin
    int n;
    logic saw_we;
    reset = 1'b0;
    mem_ack = 1'b0;
    mem_rdata = '0;
    drive_idle();
    repeat (3) tick();
    chk_quiet("rst");
`ifdef WB_FWD_EN
    chk("rst_fwd_valid", 32'(fwd_valid), 32'd0);
`endif
    reset = 1'b1;
    tick();

    // single ALU op
    drive_op(1'b0, 4'd3, 8'h5A);
    tick();
    drive_idle();
    chk("alu_we",   32'(write_en), 32'd1);
    chk("alu_dest", 32'(wr_dest),  32'd3);
    chk("alu_data", 32'(data_in),  32'h5A);
`ifdef WB_FWD_EN
    chk("alu_fwd_valid", 32'(fwd_valid), 32'd1);
    chk("alu_fwd_data",  32'(fwd_data),  32'h5A);
`endif
    tick();
    chk("alu_we_drop", 32'(write_en), 32'd0);
    chk("alu_idle",    32'(fsm_state), 32'd0);

    // three ALU ops back to back
    for (int i = 0; i < 3; i++) begin
      drive_op(1'b0, dests[i], datas[i]);
      tick();
      chk($sformatf("b2b%0d_we", i),    32'(write_en), 32'd1);
      chk($sformatf("b2b%0d_dest", i),  32'(wr_dest),  32'(dests[i]));
      chk($sformatf("b2b%0d_data", i),  32'(data_in),  32'(datas[i]));
      chk($sformatf("b2b%0d_ready", i), 32'(ex_ready), 32'd1);
    end
    drive_idle();
    tick();
    chk("b2b_we_drop", 32'(write_en), 32'd0);

    // load acked in the 4th wait cycle; an ALU op offered mid-wait must be ignored
    drive_op(1'b1, 4'd7, 8'h40);
    tick();
    drive_idle();
    for (int k = 1; k <= 4; k++) begin
      chk($sformatf("ld_w%0d_req", k),   32'(mem_req),  32'd1);
      chk($sformatf("ld_w%0d_addr", k),  32'(mem_addr), 32'h40);
      chk($sformatf("ld_w%0d_ready", k), 32'(ex_ready), 32'd0);
      chk($sformatf("ld_w%0d_we", k),    32'(write_en), 32'd0);
      if (k == 2) drive_op(1'b0, 4'd9, 8'hEE);
      else drive_idle();
      if (k == 4) begin
        mem_ack = 1'b1;
        mem_rdata = 8'hC3;
      end
      tick();
    end
    mem_ack = 1'b0;
    drive_idle();
    chk("ld_we",    32'(write_en), 32'd1);
    chk("ld_dest",  32'(wr_dest),  32'd7);
    chk("ld_data",  32'(data_in),  32'hC3);
    chk("ld_req",   32'(mem_req),  32'd0);
    chk("ld_ready", 32'(ex_ready), 32'd1);
    tick();
    chk("ld_we_drop", 32'(write_en), 32'd0);

    // stray ack while idle
    mem_ack = 1'b1;
    mem_rdata = 8'hFF;
    tick();
    mem_ack = 1'b0;
    chk("stray_we",    32'(write_en), 32'd0);
    chk("stray_data",  32'(data_in),  32'hC3);
    chk("stray_state", 32'(fsm_state), 32'd0);

    // ack on the 15th (final) wait cycle still wins
    drive_op(1'b1, 4'd4, 8'h30);
    tick();
    drive_idle();
    n = 0;
    for (int k = 1; k <= 15; k++) begin
      if (mem_req) n++;
      if (k == 15) begin
        mem_ack = 1'b1;
        mem_rdata = 8'hA5;
      end
      tick();
    end
    mem_ack = 1'b0;
    chk("edge_req_cycles", 32'(n), 32'd15);
    chk("edge_we",   32'(write_en), 32'd1);
    chk("edge_data", 32'(data_in),  32'hA5);
    chk("edge_dest", 32'(wr_dest),  32'd4);
    chk("edge_err",  32'(err),      32'd0);
    tick();

    // load timeout
    drive_op(1'b1, 4'd5, 8'h20);
    tick();
    drive_idle();
    n = 0;
    saw_we = 1'b0;
    while (mem_req && n < 40) begin
      n++;
      if (write_en) saw_we = 1'b1;
      tick();
    end
    chk("tmo_req_cycles", 32'(n),        32'd15);
    chk("tmo_err",        32'(err),      32'd1);
    chk("tmo_no_we_wait", 32'(saw_we),   32'd0);
    chk("tmo_we",         32'(write_en), 32'd0);
    chk("tmo_state",      32'(fsm_state), 32'd0);
    chk("tmo_ready",      32'(ex_ready), 32'd1);
    drive_op(1'b0, 4'd9, 8'h77);
    tick();
    drive_idle();
    chk("post_tmo_we",   32'(write_en), 32'd1);
    chk("post_tmo_dest", 32'(wr_dest),  32'd9);
    chk("post_tmo_data", 32'(data_in),  32'h77);
    chk("post_tmo_err",  32'(err),      32'd1);
    tick();
    tick();
    chk("err_sticky", 32'(err), 32'd1);

    // reset mid-load, then a late ack
    drive_op(1'b1, 4'd6, 8'h50);
    tick();
    drive_idle();
    tick();
    chk("rl_in_wait", 32'(fsm_state), 32'd1);
    reset = 1'b0;
    #1;
    chk_quiet("rl_async");
    tick();
    reset = 1'b1;
    mem_ack = 1'b1;
    mem_rdata = 8'h99;
    tick();
    mem_ack = 1'b0;
    tick();
    chk_quiet("rl_late_ack");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/wb_stage.md
WB_STAGE -- requirements
Module: wb_stage

Interface
REQ-001 Parameter W, default 8, data path width; SHALL match the register file data width.
REQ-002 Parameter D, default 4, register pointer width.
REQ-003 Parameter TMO, default 15, maximum number of LOAD_WAIT cycles before a load is abandoned.
REQ-004 Port CLK  input  1  the single clock; all state SHALL update on its rising edge.
REQ-005 Port reset  input  1  asynchronous, active-low reset.
REQ-006 Port ex_valid  input  1  the execute stage presents a retiring operation.
REQ-007 Port ex_ready  output  1  wb_stage accepts the operation this cycle.
REQ-008 Port ex_is_load  input  1  1 = load (ex_result is the address), 0 = ALU result.
REQ-009 Port ex_dest  input  D  destination register index.
REQ-010 Port ex_result  input  W  ALU result or load address.
REQ-011 Port mem_req  output  1  data-memory read request.
REQ-012 Port mem_addr  output  W  data-memory read address.
REQ-013 Port mem_ack  input  1  memory read data valid.
REQ-014 Port mem_rdata  input  W  memory read data.
REQ-015 Port write_en  output  1  register file write strobe.
REQ-016 Port wr_dest  output  D  register file write index.
REQ-017 Port data_in  output  W  register file write data.
REQ-018 Port err  output  1  sticky load-timeout flag.

Function
REQ-019 wb_stage SHALL implement the states IDLE, LOAD_WAIT and WRITE, and all outputs SHALL be registered.
REQ-020 In IDLE and WRITE, ex_ready SHALL be 1; in LOAD_WAIT, ex_ready SHALL be 0.
REQ-021 An accepted operation (ex_valid & ex_ready) with ex_is_load=0 SHALL move the block to WRITE with data_in=ex_result and wr_dest=ex_dest (1-cycle latency).
REQ-022 An accepted operation with ex_is_load=1 SHALL move the block to LOAD_WAIT, and on the next cycle mem_req=1, mem_addr=ex_result, with ex_dest latched.
REQ-023 In LOAD_WAIT, mem_req and mem_addr SHALL hold steady until mem_ack.
REQ-024 On mem_ack, the block SHALL capture mem_rdata into data_in, drop mem_req, and enter WRITE.
REQ-025 In WRITE, write_en SHALL be 1 for exactly that cycle; the next state SHALL be IDLE unless a new operation is accepted, which allows one ALU op per cycle back-to-back.
REQ-026 The wait counter SHALL clear on LOAD_WAIT entry and increment each LOAD_WAIT cycle without mem_ack.
REQ-027 When the counter reaches TMO without mem_ack, the block SHALL drop mem_req, set err, perform no write, and return to IDLE.
REQ-028 mem_ack in the cycle the counter reaches TMO SHALL win: the load completes normally and err is unchanged.
REQ-029 mem_ack outside LOAD_WAIT SHALL be ignored.
REQ-030 ex_valid while ex_ready=0 SHALL have no effect; the execute stage holds the operation.
REQ-031 err SHALL be sticky until reset.

Reset
REQ-032 When reset=0, the block SHALL asynchronously enter IDLE with ex_ready=1 and mem_req, write_en, err, counter, mem_addr, wr_dest and data_in all 0.
REQ-033 Reset asserted mid-load SHALL abandon the load and generate no write; mem_ack arriving after reset is released SHALL be ignored.

Configuration
REQ-034 With macro WB_FWD_EN defined, the block SHALL add outputs fwd_valid (1), fwd_dest (D) and fwd_data (W), equal to write_en, wr_dest and data_in, for decode-stage forwarding.
REQ-035 Without WB_FWD_EN, these ports SHALL be absent and behaviour is otherwise identical.

Verification
REQ-036 Reset released, ALU op with ex_dest=3 and ex_result=0x5A -> the next cycle write_en=1, wr_dest=3, data_in=0x5A, and the following cycle write_en=0.
REQ-037 Three consecutive ALU ops (dest 1/2/3, data 0x11/0x22/0x33) -> three consecutive write_en cycles in order, with ex_ready held at 1.
REQ-038 Load with addr 0x40 and dest 7, mem_ack after 4 cycles with 0xC3 -> mem_req high 4 cycles with mem_addr=0x40, ex_ready=0, then write_en=1, wr_dest=7, data_in=0xC3.
REQ-039 Load with no mem_ack -> mem_req drops after TMO=15 wait cycles, err=1, no write_en, and a following ALU op writes normally.
REQ-040 mem_ack exactly on the 15th wait cycle -> write occurs and err stays 0.
REQ-041 reset=0 during LOAD_WAIT, then a late mem_ack after release -> no write_en, state IDLE, all outputs 0.
